// File: rtl/aes_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the key schedule and S-box.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } aes_ks_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon_f(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      r = r | ((rnd == 4'(i)) ? RCON[i] : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? aa : 8'h00);
      aa  = gf_xtime(aa);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] x2_s, x3_s, x12_s, x15_s, x240_s, inv_s;

  // Inverse as x^254 via an addition chain (0 maps to 0 for free).
  always_comb begin
    x2_s   = gf_mul(data_i, data_i);
    x3_s   = gf_mul(x2_s, data_i);
    x12_s  = gf_mul(gf_mul(x3_s, x3_s), gf_mul(x3_s, x3_s));
    x15_s  = gf_mul(x12_s, x3_s);
    x240_s = gf_mul(gf_mul(gf_mul(x15_s, x15_s), gf_mul(x15_s, x15_s)),
                    gf_mul(gf_mul(x15_s, x15_s), gf_mul(x15_s, x15_s)));
    x240_s = gf_mul(x240_s, x240_s);
    inv_s  = gf_mul(gf_mul(x240_s, x12_s), x2_s);
    data_o = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
           ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock, all eleven keys held once done.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         keys_valid,
  output logic [127:0] key,
  output logic [127:0] round1_key,
  output logic [127:0] round2_key,
  output logic [127:0] round3_key,
  output logic [127:0] round4_key,
  output logic [127:0] round5_key,
  output logic [127:0] round6_key,
  output logic [127:0] round7_key,
  output logic [127:0] round8_key,
  output logic [127:0] round9_key,
  output logic [127:0] round10_key
);

  aes_ks_state_e state_q, state_d;
  logic [3:0]    rnd_q;
  logic          keys_valid_q;
  aes_block_t    key_q;
  aes_block_t    rk_q [1:10];

  logic       accept_s;
  logic       last_s;
  aes_block_t prev_s;
  aes_word_t  rot_s, sub_s, t_s;
  aes_word_t  w0_s, w1_s, w2_s, w3_s;

  assign last_s = (rnd_q == 4'(AES_NR));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = key_valid ? EXPAND : IDLE;
      EXPAND:  state_d = last_s ? IDLE : EXPAND;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    key_ready = 1'b0;
    accept_s  = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        accept_s  = key_valid;
      end
      EXPAND: begin
        key_ready = 1'b0;
        accept_s  = 1'b0;
      end
      default: begin
        key_ready = 1'b0;
        accept_s  = 1'b0;
      end
    endcase
  end

  // Select the previously written round key and form RotWord of its last word.
  always_comb begin
    case (rnd_q)
      4'd2:    prev_s = rk_q[1];
      4'd3:    prev_s = rk_q[2];
      4'd4:    prev_s = rk_q[3];
      4'd5:    prev_s = rk_q[4];
      4'd6:    prev_s = rk_q[5];
      4'd7:    prev_s = rk_q[6];
      4'd8:    prev_s = rk_q[7];
      4'd9:    prev_s = rk_q[8];
      4'd10:   prev_s = rk_q[9];
      default: prev_s = key_q;
    endcase
    rot_s = {prev_s[23:0], prev_s[31:24]};
  end

  for (genvar i = 0; i < AES_NK; i++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot_s[8*i +: 8]),
      .data_o (sub_s[8*i +: 8])
    );
  end

  // XOR chain producing the next four words.
  always_comb begin
    t_s  = sub_s ^ {rcon_f(rnd_q), 24'h000000};
    w0_s = prev_s[127:96] ^ t_s;
    w1_s = prev_s[95:64]  ^ w0_s;
    w2_s = prev_s[63:32]  ^ w1_s;
    w3_s = prev_s[31:0]   ^ w2_s;
  end

  // Key, round-key and progress registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q        <= 4'd0;
      keys_valid_q <= 1'b0;
      key_q        <= 128'h0;
      for (int i = 1; i <= 10; i++) begin
        rk_q[i] <= 128'h0;
      end
    end else if (accept_s) begin
      key_q        <= key_in;
      keys_valid_q <= 1'b0;
      rnd_q        <= 4'd1;
    end else if (state_q == EXPAND) begin
      for (int i = 1; i <= 10; i++) begin
        if (rnd_q == 4'(i)) begin
          rk_q[i] <= {w0_s, w1_s, w2_s, w3_s};
        end
      end
      if (last_s) begin
        keys_valid_q <= 1'b1;
        rnd_q        <= 4'd0;
      end else begin
        rnd_q <= rnd_q + 4'd1;
      end
    end
  end

  assign keys_valid  = keys_valid_q;
  assign key         = key_q;
  assign round1_key  = rk_q[1];
  assign round2_key  = rk_q[2];
  assign round3_key  = rk_q[3];
  assign round4_key  = rk_q[4];
  assign round5_key  = rk_q[5];
  assign round6_key  = rk_q[6];
  assign round7_key  = rk_q[7];
  assign round8_key  = rk_q[8];
  assign round9_key  = rk_q[9];
  assign round10_key = rk_q[10];

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a word-level FIPS-197 expansion model.
module tb_aes_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         keys_valid;
  logic [127:0] dut_rk [0:10];

  int n_checks;
  int n_fail;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];

  aes_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_in      (key_in),
    .key_ready   (key_ready),
    .keys_valid  (keys_valid),
    .key         (dut_rk[0]),
    .round1_key  (dut_rk[1]),
    .round2_key  (dut_rk[2]),
    .round3_key  (dut_rk[3]),
    .round4_key  (dut_rk[4]),
    .round5_key  (dut_rk[5]),
    .round6_key  (dut_rk[6]),
    .round7_key  (dut_rk[7]),
    .round8_key  (dut_rk[8]),
    .round9_key  (dut_rk[9]),
    .round10_key (dut_rk[10])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %032h expected %032h", tag, obs, exp);
    end
  endtask

  // S-box table from the generator-3 walk over GF(2^8)*.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r <= 10; r++) check($sformatf("%s_rk%0d", tag, r), dut_rk[r], exp_rk[r]);
  endtask

  // Present a key for one edge, then follow the whole expansion cycle by cycle.
  task automatic run_key(input logic [127:0] k, input string tag);
    model_expand(k);
    key_valid = 1'b1;
    key_in    = k;
    tick();
    key_valid = 1'b0;
    key_in    = $urandom();
    check({tag, "_key"}, dut_rk[0], exp_rk[0]);
    check({tag, "_vld0"}, {127'h0, keys_valid}, 128'h0);
    for (int n = 1; n <= 10; n++) begin
      tick();
      check($sformatf("%s_r%0d", tag, n), dut_rk[n], exp_rk[n]);
      check($sformatf("%s_vld%0d", tag, n), {127'h0, keys_valid}, (n == 10) ? 128'h1 : 128'h0);
      check($sformatf("%s_rdy%0d", tag, n), {127'h0, key_ready}, (n == 10) ? 128'h1 : 128'h0);
    end
  endtask

  initial begin
    logic [127:0] k1, k2, held;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = 128'h0;
    build_sbox();
    #3;
    check("rst_rdy", {127'h0, key_ready}, 128'h1);
    check("rst_vld", {127'h0, keys_valid}, 128'h0);
    for (int r = 0; r <= 10; r++) check($sformatf("rst_rk%0d", r), dut_rk[r], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, "a1");
    check("a1_r1_const", dut_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("a1_r10_const", dut_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_all("a1_final");

    run_key(128'h0, "zero");
    check("zero_r1_const", dut_rk[1], 128'h62636363626363636263636362636363);
    check("zero_r10_const", dut_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int i = 0; i < 4; i++) begin
      run_key({$urandom(), $urandom(), $urandom(), $urandom()}, $sformatf("rnd%0d", i));
      check_all($sformatf("rnd%0d_final", i));
    end

    // Second key held high during expansion must wait for IDLE.
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_expand(k1);
    key_valid = 1'b1;
    key_in    = k1;
    tick();
    key_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 3) begin
        key_valid = 1'b1;
        key_in    = k2;
      end
      tick();
      check($sformatf("hold_key%0d", n), dut_rk[0], k1);
    end
    check("hold_vld_up", {127'h0, keys_valid}, 128'h1);
    check_all("hold_k1");
    tick();
    key_valid = 1'b0;
    check("hold_k2_acc", dut_rk[0], k2);
    check("hold_vld_drop", {127'h0, keys_valid}, 128'h0);
    model_expand(k2);
    for (int n = 1; n <= 10; n++) tick();
    check("hold_k2_vld", {127'h0, keys_valid}, 128'h1);
    check_all("hold_k2");

    // Reset in the middle of an expansion.
    key_valid = 1'b1;
    key_in    = k1;
    tick();
    key_valid = 1'b0;
    for (int n = 1; n <= 5; n++) tick();
    rst_n = 1'b0;
    #2;
    check("mrst_vld", {127'h0, keys_valid}, 128'h0);
    check("mrst_rdy", {127'h0, key_ready}, 128'h1);
    for (int r = 0; r <= 10; r++) check($sformatf("mrst_rk%0d", r), dut_rk[r], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, "post");
    check_all("post_final");

    // Outputs stay put while idle.
    for (int n = 0; n < 50; n++) tick();
    check("idle_vld", {127'h0, keys_valid}, 128'h1);
    check("idle_rdy", {127'h0, key_ready}, 128'h1);
    check_all("idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
